// File: rtl/accum_pkg.sv
// Shared types and constants for the accumulator sequencer.
package accum_pkg;
  localparam int DATA_W = 8;

  localparam logic [DATA_W-1:0] SAT_POS = 8'h7F;
  localparam logic [DATA_W-1:0] SAT_NEG = 8'h80;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;
endpackage

// File: rtl/accum_sequencer_if.sv
// Command, external-adder and status signals of the accumulator sequencer.
interface accum_sequencer_if;
  import accum_pkg::*;

  logic              START;
  logic [DATA_W-1:0] OP_IN;
  logic              SEL_IN;
  logic              CLR;
  logic [DATA_W-1:0] X;
  logic [DATA_W-1:0] Y;
  logic              SEL;
  logic [DATA_W-1:0] DATA_IN;
  logic              CNEXT_IN;
  logic [DATA_W-1:0] ACC;
  logic              CARRY;
  logic              ZERO;
  logic              OVF;
  logic              BUSY;
  logic              DONE;
  logic [DATA_W-1:0] OP_CNT;

  modport slave (
    input  START, OP_IN, SEL_IN, CLR, DATA_IN, CNEXT_IN,
    output X, Y, SEL, ACC, CARRY, ZERO, OVF, BUSY, DONE, OP_CNT
  );

  modport master (
    output START, OP_IN, SEL_IN, CLR, DATA_IN, CNEXT_IN,
    input  X, Y, SEL, ACC, CARRY, ZERO, OVF, BUSY, DONE, OP_CNT
  );
endinterface

// File: rtl/accum_flags.sv
// Zero/signed-overflow flags and the value written back to ACC.
// ACC_SAT_EN: clamp ACC to SAT_POS/SAT_NEG on overflow instead of wrapping.
module accum_flags
  import accum_pkg::*;
(
  input  logic              x_msb,
  input  logic              y_msb,
  input  logic              sel,
  input  logic [DATA_W-1:0] sum,
  output logic [DATA_W-1:0] acc_next,
  output logic              zero,
  output logic              ovf
);
  logic y_eff_msb;

  always_comb begin
    // subtraction feeds ~Y into the adder, so the effective operand sign flips
    y_eff_msb = y_msb ^ sel;
    ovf       = (x_msb == y_eff_msb) && (sum[DATA_W-1] != x_msb);
`ifdef ACC_SAT_EN
    if (ovf) begin
      acc_next = x_msb ? SAT_NEG : SAT_POS;
    end else begin
      acc_next = sum;
    end
`else
    acc_next = sum;
`endif
    zero = (acc_next == '0);
  end
endmodule

// File: rtl/accum_sequencer.sv
// IDLE->EXEC->WB sequencer driving an external adder; one result per command, DONE in WB.
// ACC_SAT_EN (in accum_flags) selects saturating instead of wrapping writeback.
module accum_sequencer
  import accum_pkg::*;
(
  input  logic              CLK,
  input  logic              RESET,
  accum_sequencer_if.slave  bus
);
  state_t            state, state_nxt;
  logic [DATA_W-1:0] y_q;
  logic              sel_q;
  logic [DATA_W-1:0] acc_q;
  logic              carry_q;
  logic              zero_q;
  logic              ovf_q;
  logic [DATA_W-1:0] cnt_q;
  logic              busy;
  logic              done;
  logic [DATA_W-1:0] acc_next;
  logic              zero_w;
  logic              ovf_w;

  accum_flags u_flags (
    .x_msb    (acc_q[DATA_W-1]),
    .y_msb    (y_q[DATA_W-1]),
    .sel      (sel_q),
    .sum      (bus.DATA_IN),
    .acc_next (acc_next),
    .zero     (zero_w),
    .ovf      (ovf_w)
  );

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Commands are only looked at in IDLE; anything arriving while busy is dropped.
  always_comb begin
    state_nxt = state;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.CLR && bus.START) begin
          state_nxt = EXEC;
        end
      end
      EXEC: begin
        busy      = 1'b1;
        state_nxt = WB;
      end
      WB: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      y_q     <= '0;
      sel_q   <= 1'b0;
      acc_q   <= '0;
      carry_q <= 1'b0;
      zero_q  <= 1'b1;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.CLR) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b1;
            ovf_q   <= 1'b0;
          end else if (bus.START) begin
            y_q   <= bus.OP_IN;
            sel_q <= bus.SEL_IN;
          end
        end
        EXEC: begin
          acc_q   <= acc_next;
          carry_q <= bus.CNEXT_IN;
          zero_q  <= zero_w;
          ovf_q   <= ovf_w;
          cnt_q   <= cnt_q + 8'd1;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.X      = acc_q;
  assign bus.Y      = y_q;
  assign bus.SEL    = sel_q;
  assign bus.ACC    = acc_q;
  assign bus.CARRY  = carry_q;
  assign bus.ZERO   = zero_q;
  assign bus.OVF    = ovf_q;
  assign bus.BUSY   = busy;
  assign bus.DONE   = done;
  assign bus.OP_CNT = cnt_q;
endmodule

// File: tb/tb_accum_sequencer.sv
// Directed bench for accum_sequencer with a behavioural model of the external adder.
module tb_accum_sequencer;
  logic CLK;
  logic RESET;
  int   checks;
  int   errors;
  logic [7:0] exp_cnt;

  accum_sequencer_if bus ();

  accum_sequencer dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // external adder: X + Y, or X + ~Y + 1 for subtract
  logic [8:0] sum9;
  always_comb sum9 = {1'b0, bus.X} + {1'b0, (bus.SEL ? ~bus.Y : bus.Y)} + {8'd0, bus.SEL};
  assign bus.DATA_IN  = sum9[7:0];
  assign bus.CNEXT_IN = sum9[8];

`ifdef ACC_SAT_EN
  localparam logic [7:0] OVF_POS_ACC = 8'h7F;
  localparam logic [7:0] OVF_NEG_ACC = 8'h80;
`else
  localparam logic [7:0] OVF_POS_ACC = 8'h80;
  localparam logic [7:0] OVF_NEG_ACC = 8'h7F;
`endif

  typedef struct {
    logic       clr;
    logic [7:0] op;
    logic       sel;
    logic [7:0] acc;
    logic       carry;
    logic       zero;
    logic       ovf;
  } vec_t;

  vec_t tbl [13];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic do_clr(input string tag);
    bus.CLR = 1'b1;
    @(posedge CLK); #1;
    bus.CLR = 1'b0;
    check({tag, "_clr_busy"}, bus.BUSY, 0);
    check({tag, "_clr_done"}, bus.DONE, 0);
  endtask

  task automatic do_op(input string tag, input logic [7:0] op, input logic sel);
    bus.START  = 1'b1;
    bus.OP_IN  = op;
    bus.SEL_IN = sel;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    check({tag, "_exec_busy"}, bus.BUSY, 1);
    check({tag, "_exec_done"}, bus.DONE, 0);
    check({tag, "_exec_y"}, bus.Y, op);
    check({tag, "_exec_sel"}, bus.SEL, sel);
    @(posedge CLK); #1;
    exp_cnt++;
    check({tag, "_wb_done"}, bus.DONE, 1);
    check({tag, "_wb_busy"}, bus.BUSY, 1);
    @(posedge CLK); #1;
    check({tag, "_idle_done"}, bus.DONE, 0);
    check({tag, "_idle_busy"}, bus.BUSY, 0);
  endtask

  task automatic check_reset_vals(input string tag);
    check({tag, "_x"}, bus.X, 8'h00);
    check({tag, "_y"}, bus.Y, 8'h00);
    check({tag, "_sel"}, bus.SEL, 0);
    check({tag, "_acc"}, bus.ACC, 8'h00);
    check({tag, "_carry"}, bus.CARRY, 0);
    check({tag, "_zero"}, bus.ZERO, 1);
    check({tag, "_ovf"}, bus.OVF, 0);
    check({tag, "_busy"}, bus.BUSY, 0);
    check({tag, "_done"}, bus.DONE, 0);
    check({tag, "_opcnt"}, bus.OP_CNT, 8'h00);
  endtask

  initial begin
    int done_seen;
    checks  = 0;
    errors  = 0;
    exp_cnt = 8'h00;

    //          clr   op     sel   acc          carry zero  ovf
    tbl[0]  = '{1'b1, 8'h00, 1'b0, 8'h00,       1'b0, 1'b1, 1'b0};
    tbl[1]  = '{1'b0, 8'h11, 1'b0, 8'h11,       1'b0, 1'b0, 1'b0};
    tbl[2]  = '{1'b0, 8'h11, 1'b1, 8'h00,       1'b1, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 8'hAA, 1'b0, 8'hAA,       1'b0, 1'b0, 1'b0};
    tbl[4]  = '{1'b0, 8'h55, 1'b0, 8'hFF,       1'b0, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 8'h01, 1'b0, 8'h00,       1'b1, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 8'h7F, 1'b0, 8'h7F,       1'b0, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 8'h01, 1'b0, OVF_POS_ACC, 1'b0, 1'b0, 1'b1};
    tbl[8]  = '{1'b1, 8'h00, 1'b0, 8'h00,       1'b0, 1'b1, 1'b0};
    tbl[9]  = '{1'b0, 8'h01, 1'b1, 8'hFF,       1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 8'h81, 1'b0, 8'h80,       1'b1, 1'b0, 1'b0};
    tbl[11] = '{1'b0, 8'h01, 1'b1, OVF_NEG_ACC, 1'b1, 1'b0, 1'b1};
    tbl[12] = '{1'b1, 8'h00, 1'b0, 8'h00,       1'b0, 1'b1, 1'b0};

    RESET      = 1'b0;
    bus.START  = 1'b0;
    bus.OP_IN  = 8'h00;
    bus.SEL_IN = 1'b0;
    bus.CLR    = 1'b0;
    #1 RESET = 1'b1;
    @(posedge CLK); #1;
    check_reset_vals("rst");
    RESET = 1'b0;

    for (int i = 0; i < 13; i++) begin
      string tag;
      tag = $sformatf("row%0d", i);
      if (tbl[i].clr) do_clr(tag);
      else do_op(tag, tbl[i].op, tbl[i].sel);
      check({tag, "_acc"}, bus.ACC, tbl[i].acc);
      check({tag, "_x"}, bus.X, tbl[i].acc);
      check({tag, "_carry"}, bus.CARRY, tbl[i].carry);
      check({tag, "_zero"}, bus.ZERO, tbl[i].zero);
      check({tag, "_ovf"}, bus.OVF, tbl[i].ovf);
      check({tag, "_opcnt"}, bus.OP_CNT, exp_cnt);
    end

    // CLR wins over START in IDLE; START is not remembered
    do_op("pre_prio", 8'h42, 1'b0);
    bus.CLR   = 1'b1;
    bus.START = 1'b1;
    bus.OP_IN = 8'h09;
    @(posedge CLK); #1;
    bus.CLR   = 1'b0;
    bus.START = 1'b0;
    check("prio_busy", bus.BUSY, 0);
    check("prio_acc", bus.ACC, 8'h00);
    check("prio_zero", bus.ZERO, 1);
    check("prio_y", bus.Y, 8'h42);
    @(posedge CLK); #1;
    check("prio_no_start", bus.BUSY, 0);
    check("prio_opcnt", bus.OP_CNT, exp_cnt);

    // START during EXEC and CLR during WB are both ignored
    done_seen  = 0;
    bus.START  = 1'b1;
    bus.OP_IN  = 8'h05;
    bus.SEL_IN = 1'b0;
    @(posedge CLK); #1;
    bus.OP_IN = 8'h10;
    if (bus.DONE) done_seen++;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    bus.CLR   = 1'b1;
    if (bus.DONE) done_seen++;
    @(posedge CLK); #1;
    bus.CLR = 1'b0;
    exp_cnt++;
    for (int c = 0; c < 4; c++) begin
      if (bus.DONE) done_seen++;
      @(posedge CLK); #1;
    end
    check("busy_ign_done_cnt", done_seen, 1);
    check("busy_ign_acc", bus.ACC, 8'h05);
    check("busy_ign_zero", bus.ZERO, 0);
    check("busy_ign_opcnt", bus.OP_CNT, exp_cnt);

    // asynchronous reset while in EXEC
    bus.START  = 1'b1;
    bus.OP_IN  = 8'h33;
    bus.SEL_IN = 1'b1;
    @(posedge CLK); #1;
    bus.START = 1'b0;
    check("mid_rst_in_exec", bus.BUSY, 1);
    #2 RESET = 1'b1;
    #1;
    check_reset_vals("mid_rst");
    @(negedge CLK);
    RESET     = 1'b0;
    done_seen = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge CLK); #1;
      if (bus.DONE) done_seen++;
    end
    check("mid_rst_no_done", done_seen, 0);
    check("mid_rst_acc", bus.ACC, 8'h00);
    check("mid_rst_opcnt", bus.OP_CNT, 8'h00);

    // first operation after reset counts from zero
    exp_cnt = 8'h00;
    do_clr("post");
    do_op("post", 8'h11, 1'b0);
    check("post_acc", bus.ACC, 8'h11);
    check("post_carry", bus.CARRY, 0);
    check("post_zero", bus.ZERO, 0);
    check("post_opcnt", bus.OP_CNT, 8'h01);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
